// File: rtl/cotm32_pkg.sv
// Shared core types and constants: LSU access kinds, data-memory map and
// the data-memory responder state type.
package cotm32_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] DATA_MEM_START   = 32'h1000_0000;
  localparam int unsigned     DATA_MEM_SIZE    = 4096;
  localparam int unsigned     DMEM_WAIT_CYCLES = 1;

  typedef enum logic [3:0] {
    LSU_NONE    = 4'd0,
    LSU_LOAD_B  = 4'd1,
    LSU_LOAD_H  = 4'd2,
    LSU_LOAD_W  = 4'd3,
    LSU_LOAD_BU = 4'd4,
    LSU_LOAD_HU = 4'd5,
    LSU_STORE_B = 4'd6,
    LSU_STORE_H = 4'd7,
    LSU_STORE_W = 4'd8
  } lsu_ls_t;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_t;

  // Access width in bytes; 0 means no memory access.
  function automatic logic [2:0] ls_bytes(input lsu_ls_t ls);
    case (ls)
      LSU_LOAD_B, LSU_LOAD_BU, LSU_STORE_B: return 3'd1;
      LSU_LOAD_H, LSU_LOAD_HU, LSU_STORE_H: return 3'd2;
      LSU_LOAD_W, LSU_STORE_W:              return 3'd4;
      default:                              return 3'd0;
    endcase
  endfunction

  function automatic logic ls_is_store(input lsu_ls_t ls);
    return (ls == LSU_STORE_B) || (ls == LSU_STORE_H) || (ls == LSU_STORE_W);
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Data memory array: four byte lanes addressed by word index, per-lane
// synchronous write, combinational read. Contents are never reset.
module dmem_ram #(
  parameter int unsigned WORDS = 1024,
  parameter int unsigned IW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic [IW-1:0] i_idx,
  input  logic [3:0]    i_we,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata_c
);

  logic [3:0][7:0] r_mem [WORDS];

  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (i_we[l]) r_mem[i_idx][l] <= i_wdata[8*l +: 8];
    end
  end

  assign o_rdata_c = r_mem[i_idx];

endmodule

// File: rtl/dmem_responder.sv
// LSU data-memory responder: one request in flight, WAIT_CYCLES wait states,
// held response. Define COTM32_DMEM_ERR_EN to fault misaligned/out-of-range.
module dmem_responder
  import cotm32_pkg::*;
#(
  parameter int unsigned     MEM_SIZE    = DATA_MEM_SIZE,
  parameter logic [XLEN-1:0] BASE_ADDR   = DATA_MEM_START,
  parameter int unsigned     WAIT_CYCLES = DMEM_WAIT_CYCLES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  lsu_ls_t         req_ls,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err
);

  localparam int unsigned AW        = $clog2(MEM_SIZE);
  localparam int unsigned IW        = AW - 2;
  localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES - 1);

  dmem_state_t     r_state, w_state_nxt;
  logic [3:0]      r_cnt, w_cnt_nxt;
  logic [XLEN-1:0] r_addr, r_wdata;
  lsu_ls_t         r_ls;

  logic            w_accept, w_enter_resp, w_err;
  logic [XLEN-1:0] w_cur_addr, w_cur_wdata, w_offset;
  lsu_ls_t         w_cur_ls;
  logic [AW-1:0]   w_off_al;
  logic [2:0]      w_bytes;
  logic [3:0]      w_be, w_we;
  logic [31:0]     w_lane_wdata, w_ram_rdata, w_shift, w_load_data;

  assign w_accept = req_valid && req_ready;

  // In IDLE the access is taken straight from the request so a zero-wait
  // transaction can complete on its accept edge; otherwise use the latch.
  assign w_cur_addr  = (r_state == DMEM_IDLE) ? req_addr  : r_addr;
  assign w_cur_wdata = (r_state == DMEM_IDLE) ? req_wdata : r_wdata;
  assign w_cur_ls    = (r_state == DMEM_IDLE) ? req_ls    : r_ls;
  assign w_offset    = w_cur_addr - BASE_ADDR;
  assign w_bytes     = ls_bytes(w_cur_ls);

`ifdef COTM32_DMEM_ERR_EN
  assign w_err    = (w_bytes != 3'd0) &&
                    ((w_offset >= XLEN'(MEM_SIZE)) ||
                     ((w_bytes == 3'd2) && w_offset[0]) ||
                     ((w_bytes == 3'd4) && (w_offset[1:0] != 2'b00)));
  assign w_off_al = w_offset[AW-1:0];
`else
  logic w_unused;
  assign w_err    = 1'b0;
  assign w_off_al = {w_offset[AW-1:2],
                     w_offset[1] & (w_bytes != 3'd4),
                     w_offset[0] & (w_bytes == 3'd1)};
  assign w_unused = ^w_offset[XLEN-1:AW];
`endif

  // Next-state logic
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_enter_resp = 1'b0;
    unique case (r_state)
      DMEM_IDLE: begin
        if (w_accept) begin
          w_cnt_nxt = 4'd0;
          if (WAIT_CYCLES == 0) begin
            w_state_nxt  = DMEM_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_nxt = DMEM_WAIT;
          end
        end
      end
      DMEM_WAIT: begin
        if (r_cnt == WAIT_LAST) begin
          w_state_nxt  = DMEM_RESP;
          w_enter_resp = 1'b1;
          w_cnt_nxt    = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      DMEM_RESP: begin
        if (resp_ready) w_state_nxt = DMEM_IDLE;
      end
      default: w_state_nxt = DMEM_IDLE;
    endcase
  end

  // Byte-lane enables and lane-replicated store data
  always_comb begin
    w_be         = 4'b0000;
    w_lane_wdata = w_cur_wdata;
    case (w_bytes)
      3'd1: begin
        w_be         = 4'b0001 << w_off_al[1:0];
        w_lane_wdata = {4{w_cur_wdata[7:0]}};
      end
      3'd2: begin
        w_be         = w_off_al[1] ? 4'b1100 : 4'b0011;
        w_lane_wdata = {2{w_cur_wdata[15:0]}};
      end
      3'd4: w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  assign w_we = (w_enter_resp && ls_is_store(w_cur_ls) && !w_err) ? w_be : 4'b0000;

  dmem_ram #(
    .WORDS (MEM_SIZE / 4),
    .IW    (IW)
  ) u_ram (
    .clk       (clk),
    .i_idx     (w_off_al[AW-1:2]),
    .i_we      (w_we),
    .i_wdata   (w_lane_wdata),
    .o_rdata_c (w_ram_rdata)
  );

  // Load alignment and extension
  assign w_shift = w_ram_rdata >> {w_off_al[1:0], 3'b000};

  always_comb begin
    w_load_data = 32'h0;
    if (!w_err) begin
      case (w_cur_ls)
        LSU_LOAD_B:  w_load_data = {{24{w_shift[7]}}, w_shift[7:0]};
        LSU_LOAD_BU: w_load_data = {24'h0, w_shift[7:0]};
        LSU_LOAD_H:  w_load_data = {{16{w_shift[15]}}, w_shift[15:0]};
        LSU_LOAD_HU: w_load_data = {16'h0, w_shift[15:0]};
        LSU_LOAD_W:  w_load_data = w_ram_rdata;
        default:     w_load_data = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= DMEM_IDLE;
      r_cnt      <= 4'd0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_ls       <= LSU_NONE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      req_ready  <= (w_state_nxt == DMEM_IDLE);
      resp_valid <= (w_state_nxt == DMEM_RESP);
      if (w_accept) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_ls    <= req_ls;
      end
      if (w_enter_resp) begin
        resp_rdata <= w_load_data;
        resp_err   <= w_err;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed cases, randomized traffic
// against a byte-array reference model, reset abort and zero-wait throughput.
module tb_dmem_responder;
  import cotm32_pkg::*;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int unsigned MEM   = 4096;
  localparam int unsigned WAITC = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, resp_valid, resp_ready, resp_err;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  lsu_ls_t     req_ls;

  logic        rst0_n;
  logic        d0_req_valid, d0_req_ready, d0_resp_valid, d0_resp_err;
  logic [31:0] d0_req_addr, d0_req_wdata, d0_resp_rdata;
  lsu_ls_t     d0_req_ls;

  int n_checks = 0;
  int n_err    = 0;
  logic [7:0] mdl [MEM];

  always #5 clk = ~clk;

  dmem_responder #(.MEM_SIZE(MEM), .BASE_ADDR(BASE), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_ls(req_ls), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dmem_responder #(.MEM_SIZE(MEM), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst0_n), .req_valid(d0_req_valid), .req_ready(d0_req_ready),
    .req_addr(d0_req_addr), .req_ls(d0_req_ls), .req_wdata(d0_req_wdata),
    .resp_valid(d0_resp_valid), .resp_ready(1'b1),
    .resp_rdata(d0_resp_rdata), .resp_err(d0_resp_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model: byte-addressed memory, little-endian, rules applied directly.
  task automatic model(input lsu_ls_t ls, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd, output logic err);
    logic [31:0] off;
    int n;
    logic [31:0] v;
    off = addr - BASE;
    rd  = 32'h0;
    err = 1'b0;
    case (ls)
      LSU_LOAD_B, LSU_LOAD_BU, LSU_STORE_B: n = 1;
      LSU_LOAD_H, LSU_LOAD_HU, LSU_STORE_H: n = 2;
      LSU_LOAD_W, LSU_STORE_W:              n = 4;
      default:                              n = 0;
    endcase
    if (n == 0) return;
`ifdef COTM32_DMEM_ERR_EN
    if (off >= MEM || (off % n) != 0) begin
      err = 1'b1;
      return;
    end
`else
    off = off % MEM;
    off = off - (off % n);
`endif
    if (ls == LSU_STORE_B || ls == LSU_STORE_H || ls == LSU_STORE_W) begin
      for (int i = 0; i < n; i++) mdl[off + i] = wdata[8*i +: 8];
      return;
    end
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(mdl[off + i]) << (8 * i));
    if ((ls == LSU_LOAD_B || ls == LSU_LOAD_H) && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    rd = v;
  endtask

  // One full transaction on the WAIT_CYCLES=1 instance; starts and ends at a negedge.
  task automatic do_txn(input lsu_ls_t ls, input logic [31:0] addr, input logic [31:0] wdata,
                        input int hold, output logic [31:0] rd, output logic er);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          lat;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_ls = ls; req_addr = addr; req_wdata = wdata;
    model(ls, addr, wdata, exp_rd, exp_err);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_ls = LSU_STORE_W;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("resp_latency", 32'(lat), 32'(WAITC + 1));
    check("resp_rdata", resp_rdata, exp_rd);
    check("resp_err", 32'(resp_err), 32'(exp_err));
    rd = resp_rdata;
    er = resp_err;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_addr  = BASE + 32'(4 * $urandom_range(0, 63));
      req_wdata = $urandom;
      @(negedge clk);
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_rdata", resp_rdata, rd);
      check("hold_err", 32'(resp_err), 32'(er));
      check("hold_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    check("post_valid", 32'(resp_valid), 32'd0);
    check("post_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] last_w;
    lsu_ls_t     rls;

    rst_n = 1'b0; rst0_n = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_ls = LSU_NONE; resp_ready = 1'b0;
    d0_req_valid = 1'b0; d0_req_addr = '0; d0_req_wdata = '0; d0_req_ls = LSU_NONE;
    for (int i = 0; i < MEM; i++) mdl[i] = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);

    // Initialise the first 256 bytes so later loads compare against known data.
    for (int w = 0; w < 64; w++) do_txn(LSU_STORE_W, BASE + 32'(4 * w), $urandom, 0, rd, er);

    // Directed word/byte/half cases
    do_txn(LSU_STORE_W, BASE + 32'h10, 32'hDEAD_BEEF, 0, rd, er);
    check("store_w_rdata", rd, 32'h0);
    do_txn(LSU_LOAD_W, BASE + 32'h10, 32'h0, 0, rd, er);
    check("load_w", rd, 32'hDEAD_BEEF);
    check("load_w_err", 32'(er), 32'd0);
    do_txn(LSU_LOAD_B, BASE + 32'h13, 32'h0, 0, rd, er);
    check("load_b", rd, 32'hFFFF_FFDE);
    do_txn(LSU_LOAD_BU, BASE + 32'h13, 32'h0, 0, rd, er);
    check("load_bu", rd, 32'h0000_00DE);
    do_txn(LSU_LOAD_H, BASE + 32'h10, 32'h0, 0, rd, er);
    check("load_h", rd, 32'hFFFF_BEEF);
    do_txn(LSU_LOAD_HU, BASE + 32'h10, 32'h0, 0, rd, er);
    check("load_hu", rd, 32'h0000_BEEF);
    do_txn(LSU_NONE, BASE + 32'h10, 32'h1234_5678, 0, rd, er);
    check("none_rdata", rd, 32'h0);

`ifdef COTM32_DMEM_ERR_EN
    do_txn(LSU_STORE_W, BASE + 32'h2, 32'hCAFE_F00D, 0, rd, er);
    check("mis_store_err", 32'(er), 32'd1);
    do_txn(LSU_LOAD_W, BASE + 32'h1000, 32'h0, 0, rd, er);
    check("oor_err", 32'(er), 32'd1);
    check("oor_rdata", rd, 32'h0);
    do_txn(LSU_LOAD_W, BASE, 32'h0, 0, rd, er);
`else
    do_txn(LSU_LOAD_W, BASE + 32'h1010, 32'h0, 0, rd, er);
    check("wrap_load_w", rd, 32'hDEAD_BEEF);
    do_txn(LSU_LOAD_H, BASE + 32'h11, 32'h0, 0, rd, er);
    check("mis_load_h", rd, 32'hFFFF_BEEF);
    do_txn(LSU_LOAD_W, BASE + 32'h12, 32'h0, 0, rd, er);
    check("mis_load_w", rd, 32'hDEAD_BEEF);
    check("mis_err_zero", 32'(er), 32'd0);
`endif

    // Back-pressure: response held for 5 cycles with competing requests
    do_txn(LSU_LOAD_W, BASE + 32'h10, 32'h0, 5, rd, er);
    check("hold_load_w", rd, 32'hDEAD_BEEF);

    // Reset during WAIT drops the pending store
    do_txn(LSU_STORE_B, BASE + 32'h20, 32'h55, 0, rd, er);
    req_valid = 1'b1; req_ls = LSU_STORE_B; req_addr = BASE + 32'h20; req_wdata = 32'hAA;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_txn(LSU_LOAD_BU, BASE + 32'h20, 32'h0, 0, rd, er);
    check("abort_no_write", rd, 32'h0000_0055);

    // Randomized traffic over the initialised region, including aliased/out-of-range addresses
    for (int t = 0; t < 80; t++) begin
      rls = lsu_ls_t'(4'($urandom_range(0, 8)));
      do_txn(rls, BASE + 32'($urandom_range(0, 1) * MEM) + 32'($urandom_range(0, 255)),
             $urandom, int'($urandom_range(0, 2)), rd, er);
    end

    // Zero-wait instance: request held, response accepted immediately
    @(negedge clk);
    rst0_n = 1'b1;
    d0_req_valid = 1'b1; d0_req_ls = LSU_STORE_W; d0_req_addr = BASE + 32'h40;
    last_w = 32'h0;
    for (int i = 0; i < 20; i++) begin
      check("z_req_ready", 32'(d0_req_ready), 32'(i % 2 == 0));
      check("z_resp_valid", 32'(d0_resp_valid), 32'(i % 2 == 1));
      if (d0_resp_valid) check("z_store_rdata", d0_resp_rdata, 32'h0);
      d0_req_wdata = $urandom;
      if (d0_req_ready) last_w = d0_req_wdata;
      @(negedge clk);
    end
    d0_req_ls = LSU_LOAD_W;
    @(negedge clk);
    d0_req_valid = 1'b0;
    check("z_load_valid", 32'(d0_resp_valid), 32'd1);
    check("z_load_rdata", d0_resp_rdata, last_w);
    check("z_load_err", 32'(d0_resp_err), 32'd0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
